sia_work_dispatch: RTL
======================

SIA_WORK_DISPATCH -- requirements
Module: sia_work_dispatch

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, meaning the nonce result FIFO depth (power of two, at least 2).
REQ-002 SHALL provide parameter TIMEOUT, default 1024, meaning the cycles allowed in RUN without found before abandoning work (at least 2).
REQ-003 SHALL provide clk  input  1  rising-edge clock for all logic.
REQ-004 SHALL provide rst_n  input  1  reset; one clock domain; reset is synchronous and active-low.
REQ-005 SHALL provide wr_en  input  1  host word write strobe.
REQ-006 SHALL provide wr_addr  input  5  host word index.
REQ-007 SHALL provide wr_data  input  32  host write data.
REQ-008 SHALL provide start  input  1  host request to dispatch the shadow work.
REQ-009 SHALL provide work  output  640  block header to the core.
REQ-010 SHALL provide target  output  64  difficulty target to the core.
REQ-011 SHALL provide valid  output  1  single-cycle new-work pulse to the core.
REQ-012 SHALL provide found  input  1  core nonce-found pulse.
REQ-013 SHALL provide nonce  input  32  core nonce, qualified by found.
REQ-014 SHALL provide busy  input  1  core hashing indicator, status only.
REQ-015 SHALL provide res_valid  output  1  result FIFO not empty.
REQ-016 SHALL provide res_nonce  output  32  FIFO head, first-word fall-through.
REQ-017 SHALL provide res_ready  input  1  host pop acknowledge.
REQ-018 SHALL provide disp_busy  output  1  high when FSM is not IDLE.
REQ-019 SHALL provide timeout_flag  output  1  sticky flag, set when work is abandoned.
REQ-020 SHALL provide overflow_flag  output  1  sticky flag, set when a nonce is dropped.

Function
REQ-021 Shadow registers SHALL be written on wr_en in any state: addr 0..19 -> shadow work[32*a+31:32*a]; addr 20 -> target[31:0]; addr 21 -> target[63:32]; addr 22..31 ignored.
REQ-022 The FSM SHALL have states IDLE, ISSUE and RUN.
REQ-023 IDLE with start=1 at edge t SHALL copy shadow to work/target, set valid=1 for cycle t+1, and enter ISSUE.
REQ-024 ISSUE SHALL last exactly one cycle, with valid=1 and the timeout counter cleared, and then go to RUN; valid SHALL be 0 in every other state.
REQ-025 In RUN, the timeout counter SHALL increment every cycle.
REQ-026 found=1 in ISSUE or RUN SHALL push nonce into the FIFO and return the FSM to IDLE on the next edge.
REQ-027 In RUN, counter reaching TIMEOUT-1 with found=0 SHALL set timeout_flag and return the FSM to IDLE.
REQ-028 found and timeout in the same cycle: found SHALL win; push the nonce; timeout_flag unchanged.
REQ-029 found in IDLE SHALL be ignored; no push.
REQ-030 start outside IDLE SHALL be ignored; work/target held stable; shadow writes SHALL NOT alter work/target until the next accepted start.
REQ-031 start and wr_en in the same IDLE cycle: the dispatched work SHALL be the pre-write shadow value.
REQ-032 FIFO pop SHALL occur when res_valid && res_ready; res_nonce SHALL show the next entry the following cycle.
REQ-033 Push-to-res_valid latency SHALL be 1 cycle.
REQ-034 Push when full with a simultaneous pop SHALL succeed; push when full without a pop SHALL drop the nonce and set overflow_flag.
REQ-035 Pop when empty SHALL be ignored.
REQ-036 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; an extra pointer bit SHALL distinguish full from empty.

Reset
REQ-037 rst_n=0 at a clock edge SHALL force IDLE; valid, res_valid, disp_busy, timeout_flag and overflow_flag to 0; work and target to 0; shadow to 0; FIFO empty; counter 0.
REQ-038 Reset mid-RUN SHALL abandon the work; a found arriving while rst_n=0 SHALL NOT be captured.
REQ-039 start is honoured on the first edge with rst_n=1.

Verification
REQ-040 Write addr 0..21 with words 0x00000000..0x00000015, pulse start -> valid high exactly one cycle, and work word i = i and target = 0x00000015_00000014 on that cycle.
REQ-041 Dispatch, then found with nonce=0x1234ABCD two cycles later -> res_valid next cycle with res_nonce=0x1234ABCD, disp_busy=0 on that cycle; res_ready=1 -> res_valid=0.
REQ-042 TIMEOUT=16, dispatch, no found -> FSM in IDLE and timeout_flag=1 after exactly 16 RUN cycles; a found after that -> no push.
REQ-043 res_ready=0, five found pulses (nonces 1..5, each on a fresh dispatch) -> FIFO holds 1..4, overflow_flag=1; then a push of 6 concurrent with a pop when full -> subsequent pops yield 2,3,4,6.
REQ-044 Issue start again during RUN and write addr 0 = 0xFFFFFFFF during RUN -> no valid, work unchanged; next start from IDLE -> work[31:0]=0xFFFFFFFF.
REQ-045 rst_n=0 for one cycle during RUN with found=1 on the same edge -> all outputs 0 and FIFO empty afterwards.

Source files
------------

// File: rtl/sia_work_dispatch.sv
// sia_work_dispatch
//   Hands a block header + difficulty target to a hashing core and gathers
//   the nonces it reports back.
//   - The host fills a shadow copy of the work (20 x 32-bit words) and the
//     target (2 x 32-bit words) through wr_en/wr_addr/wr_data.
//   - A start in IDLE copies the shadow into work/target and pulses valid
//     for one cycle. The FSM then waits in RUN until found or until the
//     timeout expires.
//   - Each found nonce is pushed into a small first-word-fall-through FIFO.
//     The host drains it with res_ready.
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data host shadow-register write port
//   start                dispatch request (accepted only in IDLE)
//   work, target, valid  to the core
//   found, nonce, busy   from the core (busy is status only, not used)
//   res_valid/res_nonce/res_ready  result FIFO head and pop
//   disp_busy            FSM not in IDLE
//   timeout_flag         sticky: work was abandoned on timeout
//   overflow_flag        sticky: a nonce was dropped on a full FIFO
module sia_work_dispatch #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [4:0]   wr_addr,
    input  logic [31:0]  wr_data,
    input  logic         start,
    output logic [639:0] work,
    output logic [63:0]  target,
    output logic         valid,
    input  logic         found,
    input  logic [31:0]  nonce,
    input  logic         busy,
    output logic         res_valid,
    output logic [31:0]  res_nonce,
    input  logic         res_ready,
    output logic         disp_busy,
    output logic         timeout_flag,
    output logic         overflow_flag
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;

    state_t          state;
    logic [639:0]    shadow_work;
    logic [63:0]     shadow_tgt;
    logic [CW-1:0]   cnt;

    logic [31:0]     mem [FIFO_DEPTH];
    logic [AW:0]     wptr, rptr;   // extra MSB separates full from empty

    logic            fifo_empty, fifo_full, push_req, push, pop;

    wire unused_busy = busy;

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop        = !fifo_empty && res_ready;
    // found is only meaningful while work is outstanding
    assign push_req   = found && (state != IDLE);
    // a full FIFO still takes the push when the head leaves the same cycle
    assign push       = push_req && (!fifo_full || pop);

    assign res_valid  = !fifo_empty;
    assign res_nonce  = mem[rptr[AW-1:0]];
    assign disp_busy  = (state != IDLE);

    // Shadow registers: writable in any state, never seen by the core
    // until the next accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_work <= '0;
            shadow_tgt  <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < 20; i++)
                if (wr_addr == 5'(i)) shadow_work[32*i +: 32] <= wr_data;
            if (wr_addr == 5'd20) shadow_tgt[31:0]  <= wr_data;
            if (wr_addr == 5'd21) shadow_tgt[63:32] <= wr_data;
        end
    end

    // Dispatch FSM. The copy below reads the shadow before this edge's
    // write lands, so start+wr_en together dispatch the old contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            valid        <= 1'b0;
            work         <= '0;
            target       <= '0;
            cnt          <= '0;
            timeout_flag <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work   <= shadow_work;
                        target <= shadow_tgt;
                        valid  <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= found ? IDLE : RUN;
                end
                RUN: begin
                    // found takes priority over an expiring timeout
                    if (found) begin
                        state <= IDLE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        timeout_flag <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr          <= '0;
            rptr          <= '0;
            overflow_flag <= 1'b0;
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= nonce;
                wptr              <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            if (push_req && !push)
                overflow_flag <= 1'b1;
        end
    end

endmodule
